// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared definitions for the two-master memory arbiter: the
//               default address width and the owner encoding used for the
//               grant, the debug owner output and read-return steering.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 16;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'b00;
    localparam owner_t OWN_A    = 2'b01;
    localparam owner_t OWN_B    = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : arb_starve_cnt
// Description : Saturating wait counter for the bulk master. Counts cycles in
//               which B requests but is not granted; saturates at
//               STARVE_LIMIT. Clear takes priority over increment.
// Ports       : clk, rst_n  - clock, async active-low reset
//               i_inc       - B waiting this cycle
//               i_clr       - B granted or not requesting this cycle
//               o_count     - current wait count
// Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_cnt #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam logic [CNT_WIDTH-1:0] c_limit = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single memory port between the CPU (port A) and a
//               bulk master (port B, loader/DMA). Grant is combinational in
//               the request cycle; read data (1-cycle latency) is steered to
//               the master that issued the read. B is forced ahead of A after
//               STARVE_LIMIT consecutive waiting cycles.
// Ports       : clk, rst_n            - clock, async active-low reset
//               boot_hold             - loader owns memory, A never granted
//               a_* / b_*             - master request/grant/read-return ports
//               b_lock                - B keeps ownership while asserted
//               mem_*                 - shared memory port
//               owner                 - debug: this cycle's grant
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  boot_hold,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_wr,
    input  logic                  a_byt,
    input  logic [15:0]           a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [15:0]           a_rdata,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_wr,
    input  logic                  b_byt,
    input  logic [15:0]           b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [15:0]           b_rdata,
    input  logic                  b_lock,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic                  mem_byt,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic [1:0]            owner
);

    localparam logic [CNT_WIDTH-1:0] c_limit = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0]  w_starve_cnt;
    logic                  w_starved;
    owner_t                w_sel;
    logic                  r_locked;
    owner_t                r_rd_owner;
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic [15:0]           r_a_rdata;
    logic [15:0]           r_b_rdata;

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_starve_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (b_req && !b_gnt),
        .i_clr   (b_gnt || !b_req),
        .o_count (w_starve_cnt)
    );

    assign w_starved = (w_starve_cnt == c_limit);

    // Priority decision; every branch that selects a master also requires
    // that master's request, so w_sel is already qualified by req.
    always_comb begin
        w_sel = OWN_NONE;
        if (r_locked && b_req) begin
            w_sel = OWN_B;
        end else if (boot_hold) begin
            w_sel = b_req ? OWN_B : OWN_NONE;
        end else if (b_req && w_starved) begin
            w_sel = OWN_B;
        end else if (a_req) begin
            w_sel = OWN_A;
        end else if (b_req) begin
            w_sel = OWN_B;
        end
    end

    assign a_gnt = (w_sel == OWN_A) && a_req;
    assign b_gnt = (w_sel == OWN_B) && b_req;
    assign owner = w_sel;

    // With no grant the address bus parks on the last issued address so the
    // peripheral decode never sees a spurious select.
    always_comb begin
        mem_addr  = r_addr_hold;
        mem_wr    = 1'b0;
        mem_byt   = 1'b0;
        mem_wdata = 16'h0000;
        if (a_gnt) begin
            mem_addr  = a_addr;
            mem_wr    = a_wr;
            mem_byt   = a_byt;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_addr  = b_addr;
            mem_wr    = b_wr;
            mem_byt   = b_byt;
            mem_wdata = b_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked    <= 1'b0;
            r_rd_owner  <= OWN_NONE;
            r_addr_hold <= '0;
            r_a_rdata   <= 16'h0000;
            r_b_rdata   <= 16'h0000;
        end else begin
            // Dropping either lock or request releases ownership, even in the
            // cycle that was still granted under the lock.
            if (!b_lock || !b_req) begin
                r_locked <= 1'b0;
            end else if (b_gnt) begin
                r_locked <= 1'b1;
            end

            if (a_gnt && !a_wr) begin
                r_rd_owner <= OWN_A;
            end else if (b_gnt && !b_wr) begin
                r_rd_owner <= OWN_B;
            end else begin
                r_rd_owner <= OWN_NONE;
            end

            if (a_gnt || b_gnt) begin
                r_addr_hold <= mem_addr;
            end

            if (r_rd_owner == OWN_A) begin
                r_a_rdata <= mem_rdata;
            end
            if (r_rd_owner == OWN_B) begin
                r_b_rdata <= mem_rdata;
            end
        end
    end

    // Return data passes straight through in the return cycle and is held
    // afterwards, so each master keeps its last read value.
    assign a_rvalid = (r_rd_owner == OWN_A);
    assign b_rvalid = (r_rd_owner == OWN_B);
    assign a_rdata  = a_rvalid ? mem_rdata : r_a_rdata;
    assign b_rdata  = b_rvalid ? mem_rdata : r_b_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: a table of per-cycle
//               vectors plus hand-written starvation and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_hold;
    logic        a_req, a_wr, a_byt, a_gnt, a_rvalid;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_wr, b_byt, b_gnt, b_rvalid, b_lock;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, mem_byt;
    logic [1:0]  owner;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH   (16),
        .STARVE_LIMIT (8),
        .CNT_WIDTH    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .boot_hold (boot_hold),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_wr      (a_wr),
        .a_byt     (a_byt),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_addr    (b_addr),
        .b_wr      (b_wr),
        .b_byt     (b_byt),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .b_lock    (b_lock),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_byt   (mem_byt),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    typedef struct {
        logic        bh;
        logic        ar;  logic [15:0] aa;  logic aw; logic ab; logic [15:0] awd;
        logic        br;  logic [15:0] ba;  logic bw; logic bb; logic [15:0] bwd;
        logic        bl;
        logic [15:0] mrd;
        logic [71:0] exp;   // {a_gnt,b_gnt,owner,mem_addr,mem_wr,mem_byt,mem_wdata,a_rvalid,a_rdata,b_rvalid,b_rdata}
    } vec_t;

    function automatic logic [71:0] pack_out();
        return {a_gnt, b_gnt, owner, mem_addr, mem_wr, mem_byt, mem_wdata,
                a_rvalid, a_rdata, b_rvalid, b_rdata};
    endfunction

    function automatic vec_t mkv(
        input logic bh,
        input logic ar, input logic [15:0] aa, input logic aw, input logic ab, input logic [15:0] awd,
        input logic br, input logic [15:0] ba, input logic bw, input logic bb, input logic [15:0] bwd,
        input logic bl, input logic [15:0] mrd,
        input logic eag, input logic ebg, input logic [1:0] eown,
        input logic [15:0] emaddr, input logic emwr, input logic emb, input logic [15:0] emwd,
        input logic earv, input logic [15:0] eard, input logic ebrv, input logic [15:0] ebrd);
        vec_t v;
        v.bh = bh;
        v.ar = ar; v.aa = aa; v.aw = aw; v.ab = ab; v.awd = awd;
        v.br = br; v.ba = ba; v.bw = bw; v.bb = bb; v.bwd = bwd;
        v.bl = bl; v.mrd = mrd;
        v.exp = {eag, ebg, eown, emaddr, emwr, emb, emwd, earv, eard, ebrv, ebrd};
        return v;
    endfunction

    task automatic idle_inputs();
        boot_hold = 0; a_req = 0; a_addr = 0; a_wr = 0; a_byt = 0; a_wdata = 0;
        b_req = 0; b_addr = 0; b_wr = 0; b_byt = 0; b_wdata = 0; b_lock = 0;
        mem_rdata = 0;
    endtask

    task automatic check72(input string name, input logic [71:0] got, input logic [71:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got gnt=%b%b own=%b addr=%h wr=%b byt=%b wd=%h arv=%b ard=%h brv=%b brd=%h | want gnt=%b%b own=%b addr=%h wr=%b byt=%b wd=%h arv=%b ard=%h brv=%b brd=%h",
                name, got[71], got[70], got[69:68], got[67:52], got[51], got[50], got[49:34], got[33], got[32:17], got[16], got[15:0],
                expv[71], expv[70], expv[69:68], expv[67:52], expv[51], expv[50], expv[49:34], expv[33], expv[32:17], expv[16], expv[15:0]);
        end
    endtask

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, expv);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs sampled at
    // the falling edge.
    task automatic apply_vec(input vec_t v, input int idx);
        boot_hold = v.bh;
        a_req = v.ar; a_addr = v.aa; a_wr = v.aw; a_byt = v.ab; a_wdata = v.awd;
        b_req = v.br; b_addr = v.ba; b_wr = v.bw; b_byt = v.bb; b_wdata = v.bwd;
        b_lock = v.bl; mem_rdata = v.mrd;
        @(negedge clk);
        check72($sformatf("vec%0d", idx), pack_out(), v.exp);
        @(posedge clk); #1;
    endtask

    vec_t tbl[17];

    initial begin
        idle_inputs();
        rst_n = 0;

        //            bh ar aa    aw ab awd    br ba    bw bb bwd    bl mrd      ag bg own   maddr  mw mb mwd    arv ard    brv brd
        // A-only read at 0x0300, data returns next cycle, then held
        tbl[0]  = mkv(0, 1,16'h0300,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 0,16'h0000, 1,0,2'b01,16'h0300,0,0,16'h0000, 0,16'h0000, 0,16'h0000);
        tbl[1]  = mkv(0, 0,16'h0000,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 0,16'h1234, 0,0,2'b00,16'h0300,0,0,16'h0000, 1,16'h1234, 0,16'h0000);
        tbl[2]  = mkv(0, 0,16'h0000,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 0,16'h5555, 0,0,2'b00,16'h0300,0,0,16'h0000, 0,16'h1234, 0,16'h0000);
        // Alternating A read 0x0002 / B read 0x0400
        tbl[3]  = mkv(0, 1,16'h0002,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 0,16'h0000, 1,0,2'b01,16'h0002,0,0,16'h0000, 0,16'h1234, 0,16'h0000);
        tbl[4]  = mkv(0, 0,16'h0000,0,0,16'h0000, 1,16'h0400,0,0,16'h0000, 0,16'hAAAA, 0,1,2'b10,16'h0400,0,0,16'h0000, 1,16'hAAAA, 0,16'h0000);
        tbl[5]  = mkv(0, 1,16'h0002,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 0,16'hBBBB, 1,0,2'b01,16'h0002,0,0,16'h0000, 0,16'hAAAA, 1,16'hBBBB);
        tbl[6]  = mkv(0, 0,16'h0000,0,0,16'h0000, 1,16'h0400,0,0,16'h0000, 0,16'hCCCC, 0,1,2'b10,16'h0400,0,0,16'h0000, 1,16'hCCCC, 0,16'hBBBB);
        tbl[7]  = mkv(0, 0,16'h0000,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 0,16'hDDDD, 0,0,2'b00,16'h0400,0,0,16'h0000, 0,16'hCCCC, 1,16'hDDDD);
        // boot_hold: only B, then none, then A the same cycle boot_hold drops
        tbl[8]  = mkv(1, 1,16'h0010,1,1,16'h1111, 1,16'h0020,1,0,16'h2222, 0,16'h0000, 0,1,2'b10,16'h0020,1,0,16'h2222, 0,16'hCCCC, 0,16'hDDDD);
        tbl[9]  = mkv(1, 1,16'h0010,1,1,16'h1111, 0,16'h0000,0,0,16'h0000, 0,16'h0000, 0,0,2'b00,16'h0020,0,0,16'h0000, 0,16'hCCCC, 0,16'hDDDD);
        tbl[10] = mkv(0, 1,16'h0010,1,1,16'h1111, 1,16'h0020,1,0,16'h2222, 0,16'h0000, 1,0,2'b01,16'h0010,1,1,16'h1111, 0,16'hCCCC, 0,16'hDDDD);
        // Locked burst of 4 B writes while A requests
        tbl[11] = mkv(0, 0,16'h0000,0,0,16'h0000, 1,16'h0300,1,0,16'h0001, 1,16'h0000, 0,1,2'b10,16'h0300,1,0,16'h0001, 0,16'hCCCC, 0,16'hDDDD);
        tbl[12] = mkv(0, 1,16'h0010,1,1,16'h1111, 1,16'h0302,1,0,16'h0002, 1,16'h0000, 0,1,2'b10,16'h0302,1,0,16'h0002, 0,16'hCCCC, 0,16'hDDDD);
        tbl[13] = mkv(0, 1,16'h0010,1,1,16'h1111, 1,16'h0304,1,0,16'h0003, 1,16'h0000, 0,1,2'b10,16'h0304,1,0,16'h0003, 0,16'hCCCC, 0,16'hDDDD);
        tbl[14] = mkv(0, 1,16'h0010,1,1,16'h1111, 1,16'h0306,1,0,16'h0004, 0,16'h0000, 0,1,2'b10,16'h0306,1,0,16'h0004, 0,16'hCCCC, 0,16'hDDDD);
        tbl[15] = mkv(0, 1,16'h0010,1,1,16'h1111, 1,16'h0308,1,0,16'h0005, 0,16'h0000, 1,0,2'b01,16'h0010,1,1,16'h1111, 0,16'hCCCC, 0,16'hDDDD);
        // Both drop without grant: address bus parks on last issued address
        tbl[16] = mkv(0, 0,16'h0000,0,0,16'h0000, 0,16'h0000,0,0,16'h0000, 0,16'h0000, 0,0,2'b00,16'h0010,0,0,16'h0000, 0,16'hCCCC, 0,16'hDDDD);

        // Reset state
        #12;
        check72("reset_state", pack_out(), 72'h0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        foreach (tbl[i]) apply_vec(tbl[i], i);

        // Starvation: both masters request continuously; reference counter
        begin
            int cnt = 0;
            int b_wins = 0;
            int last_b = -1;
            for (int i = 0; i < 27; i++) begin
                logic exp_b;
                exp_b = (cnt == 8);
                a_req = 1; a_addr = 16'h0100; a_wr = 1; a_byt = 0; a_wdata = 16'h00A0;
                b_req = 1; b_addr = 16'h0200; b_wr = 1; b_byt = 0; b_wdata = 16'h00B0;
                @(negedge clk);
                check1($sformatf("starve_c%0d", i),
                       {a_gnt, b_gnt, mem_addr},
                       {!exp_b, exp_b, exp_b ? 16'h0200 : 16'h0100});
                if (b_gnt) begin
                    if (last_b >= 0) check1("starve_period", i - last_b, 9);
                    last_b = i;
                    b_wins++;
                end
                cnt = exp_b ? 0 : ((cnt == 8) ? 8 : cnt + 1);
                @(posedge clk); #1;
            end
            check1("starve_b_count", b_wins, 3);
        end
        idle_inputs();
        @(posedge clk); #1;

        // Reset during an outstanding A read drops the return
        a_req = 1; a_addr = 16'h0300; a_wr = 0;
        @(negedge clk);
        check1("rst_rd_issue", {a_gnt, mem_addr}, {1'b1, 16'h0300});
        @(posedge clk); #1;
        idle_inputs();
        mem_rdata = 16'h7777;
        rst_n = 0;
        #1;
        check1("rst_rd_drop", {a_rvalid, mem_addr, owner, a_rdata}, {1'b0, 16'h0000, 2'b00, 16'h0000});
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Reset clears the lock: after it, A wins over a lock-requesting B
        b_req = 1; b_addr = 16'h0500; b_wr = 1; b_lock = 1;
        @(negedge clk);
        check1("lock_set_gnt", {a_gnt, b_gnt}, 2'b01);
        @(posedge clk); #1;
        a_req = 1; a_addr = 16'h0010; a_wr = 1;
        @(negedge clk);
        check1("lock_held", {a_gnt, b_gnt}, 2'b01);
        rst_n = 0;
        #2;
        rst_n = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check1("lock_cleared", {a_gnt, b_gnt, owner}, {2'b10, 2'b01});
        @(posedge clk); #1;
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single MCU memory port (address, wr_mem, byt, wr_data, rd_data) between two masters.
  - Port A: the CPU.
  - Port B: a bulk master, either the UART program loader or a future DMA.
- Sits between the masters and the memory/peripheral decode.
- Arbitrates every cycle, steers the 1-cycle-latency read data back to the master that issued the read, and prevents starvation of B.

Parameters:
- ADDR_WIDTH, 16, width of all address buses.
- STARVE_LIMIT, 8, consecutive cycles B may wait before it is forced ahead of A (must be ≥1).
- CNT_WIDTH, 4, width of the starvation counter (must hold STARVE_LIMIT).

Ports:
- clk  in  1  system clock, all registers on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- boot_hold  in  1  1 = A is never granted (loader owns memory).
- a_req  in  1  A requests an access this cycle.
- a_addr  in  ADDR_WIDTH  A byte address.
- a_wr  in  1  A write (1) / read (0).
- a_byt  in  1  A byte access.
- a_wdata  in  16  A write data.
- a_gnt  out  1  A access issued this cycle.
- a_rvalid  out  1  A read data valid.
- a_rdata  out  16  A read data.
- b_req, b_addr, b_wr, b_byt, b_wdata, b_gnt, b_rvalid, b_rdata: as for A, port B.
- b_lock  in  1  B keeps ownership while asserted.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wr  out  1  memory write strobe.
- mem_byt  out  1  memory byte access.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data, valid the cycle after the address.
- owner  out  2  debug: 00 none, 01 A, 10 B (cycle's grant).

Behaviour:
- Reset values:
  - starve_cnt=0, locked=0, rd_owner=none.
  - a_rvalid=b_rvalid=0.
  - mem_addr hold register=0; a_rdata=b_rdata=0.
- Grant is combinational in the request cycle. At most one of a_gnt/b_gnt is high. A granted access reaches the memory port in the same cycle.
- Decision order, first match wins:
  1. locked=1 and b_req → B.
  2. boot_hold=1 → B if b_req, else none.
  3. b_req and starve_cnt==STARVE_LIMIT → B.
  4. a_req → A.
  5. b_req → B.
  6. Otherwise none.
- The masters' gnt = selected, and only while the corresponding req is high.
- Memory outputs while a master is granted: mem_addr/mem_wr/mem_byt/mem_wdata = that master's signals.
- Memory outputs with no grant:
  - mem_wr=0, mem_byt=0, mem_wdata=0.
  - mem_addr = last issued address (registered hold), so peripheral decode sees no spurious address.
- locked register:
  - Set on the edge after a b_gnt cycle with b_lock=1.
  - Cleared on the edge after any cycle with b_lock=0 or b_req=0.
  - While locked, A is denied even if boot_hold=0.
- starve_cnt:
  - +1 each cycle with b_req=1 and b_gnt=0, saturating at STARVE_LIMIT.
  - Cleared to 0 on any b_gnt cycle or any cycle with b_req=0.
- Read return:
  - rd_owner register = granted master if the access was a read, else none.
  - Next cycle: x_rvalid=1 for that owner only; x_rdata = mem_rdata.
  - For the non-owner, rdata holds its last value and rvalid=0.
  - Back-to-back reads by alternating masters each get their own return. Latency is exactly 1 cycle.
- Writes produce no rvalid.
- boot_hold rising mid-stream: takes effect the same cycle. An A read already issued still returns a_rvalid the next cycle.
- Asynchronous reset mid-read: the pending rvalid is dropped and the lock is cleared.
- A misbehaving master that drops req without a grant is legal. No state is kept for it except that starve_cnt clears (B case).

Decomposition:
- Shared package (common): ADDR_WIDTH default, owner encoding constants OWN_NONE/OWN_A/OWN_B.
- One sub-module: arb_starve_cnt, the saturating wait counter with clear. Everything else is inline.

Test Plan:
- A-only read at 0x0300 with mem_rdata=0x1234 next cycle → a_gnt=1 at t0, a_rvalid=1 and a_rdata=0x1234 at t1, b_rvalid=0.
- a_req and b_req held continuously, STARVE_LIMIT=8 → A granted 8 cycles, B granted on the 9th, then A again, with the repeating period checked.
- boot_hold=1, both requesting writes → only b_gnt. Then boot_hold=0 → A granted the same cycle.
- B asserts b_lock with 4 consecutive writes to 0x0300..0x0306 while a_req=1 → all 4 to B, A granted the cycle after b_lock drops.
- Alternating A read 0x0002 and B read 0x0400 → each rvalid arrives at the correct port with the matching data, no cross-delivery.
- rst_n pulled low during an outstanding A read → a_rvalid=0 after reset, mem_addr=0, owner=00, locked cleared.
